// File: rtl/me_search_fetch.sv
// Search-window store for the motion-estimation core: raster load into column-interleaved banks,
// single-cycle row reads rotated into lane order. Optional macro: ME_FETCH_OOB_CLAMP_EN.
module me_search_fetch #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [7:0]                 load_pixel,
  output logic                       load_ready,
  output logic                       win_ready,
  input  logic                       rd_en,
  input  logic [5:0]                 addr,
  input  logic [5:0]                 amt,
  output logic [8*(MACRO_DIM+1)-1:0] pixel_spr_out,
  output logic                       rd_valid,
  output logic                       rd_err
);

  localparam int PORT_WIDTH = MACRO_DIM + 1;
  localparam int NUM_GRP    = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
  localparam int BANK_DEPTH = SEARCH_DIM * NUM_GRP;
  localparam int BANK_AW    = $clog2(BANK_DEPTH);
  localparam int BANK_SW    = $clog2(PORT_WIDTH);
  localparam int CNT_W      = $clog2(SEARCH_DIM);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_e;

  state_e                    state_q;
  logic [CNT_W-1:0]          row_q, col_q;
  logic                      load_ready_q, win_ready_q;
  logic                      rd_valid_q, rd_err_q;
  logic [8*PORT_WIDTH-1:0]   pixel_q;

  logic [7:0]                bankMem [PORT_WIDTH][BANK_DEPTH];

  logic                      wrEn;
  logic [BANK_SW-1:0]        wrBank;
  logic [BANK_AW-1:0]        wrWord;

  logic                      addrOob, amtOob;
  logic [7:0]                rdAddr, rdAmt, rot;
  logic [7:0]                rdCol    [PORT_WIDTH];
  logic [BANK_AW-1:0]        rdWord   [PORT_WIDTH];
  logic [7:0]                bankData [PORT_WIDTH];
  logic [8*PORT_WIDTH-1:0]   pixel_d;
  logic                      rdErr_d;
  logic                      rdAccept;
  logic                      lastPixel;

  always_comb begin
    wrEn   = (state_q == LOAD) && load_valid && !load_start;
    wrBank = BANK_SW'(int'(col_q) % PORT_WIDTH);
    wrWord = BANK_AW'((int'(col_q) / PORT_WIDTH) * SEARCH_DIM + int'(row_q));
  end

  always_ff @(posedge clk) begin
    if (wrEn) bankMem[wrBank][wrWord] <= load_pixel;
  end

  // Every bank supplies exactly one lane: bank b serves the lane whose column is congruent to b.
  always_comb begin
    addrOob = ({2'b00, addr} >= 8'(SEARCH_DIM));
    amtOob  = ({2'b00, amt} > 8'(SEARCH_DIM - PORT_WIDTH));
`ifdef ME_FETCH_OOB_CLAMP_EN
    rdAddr  = addrOob ? 8'(SEARCH_DIM - 1) : {2'b00, addr};
    rdAmt   = amtOob ? 8'(SEARCH_DIM - PORT_WIDTH) : {2'b00, amt};
    rdErr_d = 1'b0;
`else
    rdAddr  = (addrOob || amtOob) ? 8'd0 : {2'b00, addr};
    rdAmt   = (addrOob || amtOob) ? 8'd0 : {2'b00, amt};
    rdErr_d = addrOob || amtOob;
`endif
    rot     = rdAmt % 8'(PORT_WIDTH);
    pixel_d = '0;
    for (int b = 0; b < PORT_WIDTH; b++) begin
      rdCol[b]    = rdAmt + 8'((b + PORT_WIDTH - int'(rot)) % PORT_WIDTH);
      rdWord[b]   = BANK_AW'((int'(rdCol[b]) / PORT_WIDTH) * SEARCH_DIM + int'(rdAddr));
      bankData[b] = bankMem[b][rdWord[b]];
    end
    for (int l = 0; l < PORT_WIDTH; l++) begin
      pixel_d[8*l +: 8] = bankData[(int'(rot) + l) % PORT_WIDTH];
    end
    if (rdErr_d) pixel_d = '0;
  end

  assign rdAccept  = rd_en && (state_q == READY);
  assign lastPixel = (row_q == CNT_W'(SEARCH_DIM - 1)) && (col_q == CNT_W'(SEARCH_DIM - 1));

  // A read issued alongside load_start in READY still sees the old window, since writes only begin in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      load_ready_q <= 1'b0;
      win_ready_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
      pixel_q      <= '0;
    end else begin
      rd_valid_q <= rdAccept;
      rd_err_q   <= rdAccept && rdErr_d;
      if (rdAccept) pixel_q <= pixel_d;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q      <= LOAD;
            load_ready_q <= 1'b1;
            row_q        <= '0;
            col_q        <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            row_q <= '0;
            col_q <= '0;
          end else if (load_valid) begin
            if (col_q == CNT_W'(SEARCH_DIM - 1)) begin
              col_q <= '0;
              if (lastPixel) begin
                state_q      <= READY;
                row_q        <= '0;
                load_ready_q <= 1'b0;
                win_ready_q  <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        READY: begin
          if (load_start) begin
            state_q      <= LOAD;
            load_ready_q <= 1'b1;
            win_ready_q  <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready    = load_ready_q;
  assign win_ready     = win_ready_q;
  assign rd_valid      = rd_valid_q;
  assign rd_err        = rd_err_q;
  assign pixel_spr_out = pixel_q;

endmodule

// File: tb/tb_me_search_fetch.sv
// Bench for me_search_fetch: directed vector table, corner sequences, and random reads
// against a window-array model. Honors ME_FETCH_OOB_CLAMP_EN like the design.
module tb_me_search_fetch;

  localparam int SD = 48;
  localparam int PW = 17;
  localparam int OW = 8 * PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start, load_valid;
  logic [7:0]    load_pixel;
  logic          load_ready, win_ready;
  logic          rd_en;
  logic [5:0]    addr, amt;
  logic [OW-1:0] pixel_spr_out;
  logic          rd_valid, rd_err;

  me_search_fetch dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_pixel(load_pixel), .load_ready(load_ready), .win_ready(win_ready),
    .rd_en(rd_en), .addr(addr), .amt(amt), .pixel_spr_out(pixel_spr_out),
    .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] addr;
    logic [5:0] amt;
    logic [7:0] lane0;
    logic       err;
  } vec_t;

  vec_t          vecs [8];
  logic [7:0]    win [SD][SD];
  bit            tbReady;
  logic [OW-1:0] lastPix, expPix;
  logic          expValid, expErr;
  int            vecCount, missCount;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fillWindow(input bit randomPix);
    for (int r = 0; r < SD; r++)
      for (int c = 0; c < SD; c++)
        win[r][c] = randomPix ? 8'($urandom) : 8'((r * SD + c) % 256);
  endtask

  // Lane l of a read is simply window[row][first column + l], after the out-of-range policy.
  task automatic modelRead(input logic [5:0] a, input logic [5:0] m,
                           output logic [OW-1:0] pix, output logic err);
    int ra, rm;
    ra = int'(a);
    rm = int'(m);
    pix = '0;
    err = 1'b0;
`ifdef ME_FETCH_OOB_CLAMP_EN
    if (ra > SD - 1) ra = SD - 1;
    if (rm > SD - PW) rm = SD - PW;
`else
    if (ra > SD - 1 || rm > SD - PW) begin
      err = 1'b1;
      return;
    end
`endif
    for (int l = 0; l < PW; l++) pix[8*l +: 8] = win[ra][rm + l];
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] a, input logic [5:0] m);
    rd_en = en;
    addr  = a;
    amt   = m;
    if (en && tbReady) begin
      modelRead(a, m, expPix, expErr);
      expValid = 1'b1;
      lastPix  = expPix;
    end else begin
      expValid = 1'b0;
      expErr   = 1'b0;
      expPix   = lastPix;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".rd_valid"}, OW'(rd_valid), OW'(expValid));
    checkVal({tag, ".rd_err"}, OW'(rd_err), OW'(expErr));
    checkVal({tag, ".pixels"}, pixel_spr_out, expPix);
  endtask

  task automatic readCycle(input string tag, input logic en, input logic [5:0] a, input logic [5:0] m);
    applyStimulus(en, a, m);
    tick();
    rd_en = 1'b0;
    checkOutput(tag);
  endtask

  task automatic loadWindow(input bit doStart, input bit gaps);
    if (doStart) begin
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
    end
    checkVal("load.loadReadyHigh", OW'(load_ready), OW'(1));
    checkVal("load.winReadyLow", OW'(win_ready), OW'(0));
    for (int r = 0; r < SD; r++) begin
      for (int c = 0; c < SD; c++) begin
        if (gaps && $urandom_range(0, 9) == 0) begin
          load_valid = 1'b0;
          tick();
        end
        if (r == SD - 1 && c == SD - 1)
          checkVal("load.winReadyBeforeLast", OW'(win_ready), OW'(0));
        load_valid = 1'b1;
        load_pixel = win[r][c];
        tick();
      end
    end
    load_valid = 1'b0;
    checkVal("load.winReadyAfterLast", OW'(win_ready), OW'(1));
    checkVal("load.loadReadyAfterLast", OW'(load_ready), OW'(0));
    tbReady = 1'b1;
  endtask

  initial begin
    logic [OW-1:0] tabPix;
    logic [5:0]    ra, rm;
    vecCount   = 0;
    missCount  = 0;
    tbReady    = 1'b0;
    lastPix    = '0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_pixel = '0;
    rd_en      = 1'b0;
    addr       = '0;
    amt        = '0;

    vecs[0] = '{6'd0,  6'd0,  8'd0,   1'b0};
    vecs[1] = '{6'd5,  6'd31, 8'd15,  1'b0};
    vecs[2] = '{6'd47, 6'd17, 8'd225, 1'b0};
    vecs[3] = '{6'd47, 6'd31, 8'd239, 1'b0};
    vecs[4] = '{6'd10, 6'd0,  8'd224, 1'b0};
`ifdef ME_FETCH_OOB_CLAMP_EN
    vecs[5] = '{6'd3,  6'd32, 8'd175, 1'b0};
    vecs[6] = '{6'd50, 6'd10, 8'd218, 1'b0};
    vecs[7] = '{6'd63, 6'd63, 8'd239, 1'b0};
`else
    vecs[5] = '{6'd3,  6'd32, 8'd0,   1'b1};
    vecs[6] = '{6'd50, 6'd10, 8'd0,   1'b1};
    vecs[7] = '{6'd63, 6'd63, 8'd0,   1'b1};
`endif

    #12;
    checkVal("reset.load_ready", OW'(load_ready), OW'(0));
    checkVal("reset.win_ready", OW'(win_ready), OW'(0));
    checkVal("reset.rd_valid", OW'(rd_valid), OW'(0));
    checkVal("reset.rd_err", OW'(rd_err), OW'(0));
    checkVal("reset.pixels", pixel_spr_out, OW'(0));
    rst_n = 1'b1;
    tick();

    fillWindow(1'b0);
    loadWindow(1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      readCycle($sformatf("vec%0d", i), 1'b1, vecs[i].addr, vecs[i].amt);
      tabPix = '0;
      if (!vecs[i].err)
        for (int l = 0; l < PW; l++) tabPix[8*l +: 8] = vecs[i].lane0 + 8'(l);
      checkVal($sformatf("vec%0d.table", i), pixel_spr_out, tabPix);
      checkVal($sformatf("vec%0d.tableErr", i), OW'(rd_err), OW'(vecs[i].err));
    end

    for (int i = 0; i < 32; i++)
      readCycle($sformatf("sweep%0d", i), 1'b1, 6'($urandom_range(0, SD - 1)), 6'(i));
    readCycle("sweepEnd", 1'b0, 6'd0, 6'd0);

    load_start = 1'b1;
    applyStimulus(1'b1, 6'd7, 6'd9);
    tick();
    load_start = 1'b0;
    rd_en      = 1'b0;
    checkOutput("startWithRead");
    checkVal("startWithRead.winReady", OW'(win_ready), OW'(0));
    checkVal("startWithRead.loadReady", OW'(load_ready), OW'(1));
    tbReady = 1'b0;
    readCycle("readInLoad", 1'b1, 6'd0, 6'd0);

    for (int i = 0; i < 30; i++) begin
      load_valid = 1'b1;
      load_pixel = 8'($urandom);
      tick();
    end
    load_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkVal("midReset.load_ready", OW'(load_ready), OW'(0));
    checkVal("midReset.win_ready", OW'(win_ready), OW'(0));
    checkVal("midReset.rd_valid", OW'(rd_valid), OW'(0));
    checkVal("midReset.rd_err", OW'(rd_err), OW'(0));
    checkVal("midReset.pixels", pixel_spr_out, OW'(0));
    lastPix = '0;
    #2;
    rst_n = 1'b1;
    tick();
    readCycle("readInIdle", 1'b1, 6'd0, 6'd0);
    checkVal("idle.loadReady", OW'(load_ready), OW'(0));

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      load_valid = 1'b1;
      load_pixel = 8'hAA;
      tick();
    end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    fillWindow(1'b0);
    loadWindow(1'b0, 1'b0);
    readCycle("restart0", 1'b1, 6'd0, 6'd0);
    readCycle("restart1", 1'b1, 6'd1, 6'd0);

    fillWindow(1'b1);
    loadWindow(1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(SD, 63)) : 6'($urandom_range(0, SD - 1));
      rm = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(SD - PW + 1, 63)) : 6'($urandom_range(0, SD - PW));
      readCycle($sformatf("rand%0d", i), 1'($urandom_range(0, 3) != 0), ra, rm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
